// File: rtl/uart_rx_frame.sv
// Oversampling UART receiver: baud ticks, 2-flop sync, 3-tick majority vote,
// start glitch reject, DATA_BITS/PARITY/STOP_BITS framing.
// Ports: clk, rst (async high), rx (idle high) -> data_out, data_valid,
//        parity_err, frame_err, busy.
module uart_rx_frame #(
  parameter int pBAUD_RATE    = 115200,
  parameter int pSYS_CLK_FREQ = 50_000_000,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int OVERSAMPLE    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int DIV = pSYS_CLK_FREQ / (pBAUD_RATE * OVERSAMPLE);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OW  = $clog2(OVERSAMPLE);
  localparam int IW  = $clog2(DATA_BITS);

  localparam logic [TW-1:0] TMAX   = TW'(DIV - 1);
  localparam logic [OW-1:0] OS_MID = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [OW-1:0] OS_END = OW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic          ODD_PAR = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [TW-1:0]         r_tcnt;
  logic                  w_tick;
  logic [1:0]            r_sync;
  logic                  w_rx_s;
  logic [1:0]            r_hist;
  logic                  w_maj;
  logic [OW-1:0]         r_os, w_os_nxt;
  logic [IW-1:0]         r_idx, w_idx_nxt;
  logic [DATA_BITS-1:0]  r_shift, w_shift_nxt;
  logic                  r_stop, w_stop_nxt;
  logic                  r_ferr_p, w_ferr_p_nxt;
  logic                  r_perr_p, w_perr_p_nxt;
  logic                  w_done;
  logic [DATA_BITS-1:0]  r_dout;
  logic                  r_valid, r_perr, r_ferr;

  // free-running baud*oversample tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_tcnt <= '0;
    else if (w_tick) r_tcnt <= '0;
    else r_tcnt <= r_tcnt + 1'b1;
  end
  assign w_tick = (r_tcnt == TMAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= 2'b11;
    else r_sync <= {r_sync[0], rx};
  end
  assign w_rx_s = r_sync[1];

  // previous two tick samples; vote includes the current one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_hist <= 2'b11;
    else if (w_tick) r_hist <= {r_hist[0], w_rx_s};
  end
  assign w_maj = (r_hist[1] & r_hist[0]) |
                 (r_hist[1] & w_rx_s) |
                 (r_hist[0] & w_rx_s);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_os     <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_stop   <= 1'b0;
      r_ferr_p <= 1'b0;
      r_perr_p <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_os     <= w_os_nxt;
      r_idx    <= w_idx_nxt;
      r_shift  <= w_shift_nxt;
      r_stop   <= w_stop_nxt;
      r_ferr_p <= w_ferr_p_nxt;
      r_perr_p <= w_perr_p_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_os_nxt     = r_os;
    w_idx_nxt    = r_idx;
    w_shift_nxt  = r_shift;
    w_stop_nxt   = r_stop;
    w_ferr_p_nxt = r_ferr_p;
    w_perr_p_nxt = r_perr_p;
    w_done       = 1'b0;
    if (w_tick) begin
      unique case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            w_state_nxt = S_START;
            w_os_nxt    = '0;
          end
        end
        S_START: begin
          if (r_os == OS_MID) begin
            if (w_maj) begin
              w_state_nxt = S_IDLE;
            end else begin
              w_state_nxt  = S_DATA;
              w_os_nxt     = '0;
              w_shift_nxt  = '0;
              w_idx_nxt    = '0;
              w_perr_p_nxt = 1'b0;
              w_ferr_p_nxt = 1'b0;
              w_stop_nxt   = 1'b0;
            end
          end else begin
            w_os_nxt = r_os + 1'b1;
          end
        end
        S_DATA: begin
          if (r_os == OS_END) begin
            w_os_nxt = '0;
            w_shift_nxt[r_idx] = w_maj;
            if (r_idx == IDX_LAST)
              w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
            else
              w_idx_nxt = r_idx + 1'b1;
          end else begin
            w_os_nxt = r_os + 1'b1;
          end
        end
        S_PARITY: begin
          if (r_os == OS_END) begin
            w_os_nxt     = '0;
            w_perr_p_nxt = (^r_shift) ^ w_maj ^ ODD_PAR;
            w_state_nxt  = S_STOP;
          end else begin
            w_os_nxt = r_os + 1'b1;
          end
        end
        S_STOP: begin
          if (r_os == OS_END) begin
            w_os_nxt = '0;
            if (!w_maj) w_ferr_p_nxt = 1'b1;
            // leave at mid stop bit so a following start edge is caught
            if (r_stop == STOP_LAST) begin
              w_state_nxt = S_IDLE;
              w_done      = 1'b1;
            end else begin
              w_stop_nxt = 1'b1;
            end
          end else begin
            w_os_nxt = r_os + 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_valid <= w_done;
      if (w_done) begin
        r_dout <= w_shift_nxt;
        r_perr <= w_perr_p_nxt;
        r_ferr <= w_ferr_p_nxt;
      end
    end
  end

  assign data_out   = r_dout;
  assign data_valid = r_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign busy       = (r_state != S_IDLE);

endmodule
